// File: rtl/vsub_row_sat_pipeline.sv
// Two-stage pipelined f1[i] = sat32(e[i] - temp[i]) over 8 elements, with an
// ap_start/ap_done/ap_ready/ap_idle handshake and a loop-init flow controller.
module vsub_row_sat_pipeline #(
  parameter logic [19:0] E_0 = 20'h00000,
  parameter logic [19:0] E_1 = 20'h00010,
  parameter logic [19:0] E_2 = 20'h00100,
  parameter logic [19:0] E_3 = 20'h01000,
  parameter logic [19:0] E_4 = 20'h10000,
  parameter logic [19:0] E_5 = 20'h7FFFF,
  parameter logic [19:0] E_6 = 20'hFFFFF,
  parameter logic [19:0] E_7 = 20'h00001
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [2:0]  temp_V_address0,
  output logic        temp_V_ce0,
  input  logic [31:0] temp_V_q0,
  output logic [2:0]  f1_V_address0,
  output logic        f1_V_ce0,
  output logic        f1_V_we0,
  output logic [31:0] f1_V_d0
);

  logic [3:0]  i;
  logic        init_flag;
  logic        valid1;
  logic [2:0]  idx1;
  logic [19:0] e_q;

  logic        ap_loop_init;
  logic [3:0]  index;
  logic        exit_cond;
  logic [19:0] rom_data;
  logic [32:0] ret;

  assign ap_loop_init    = init_flag & ap_start;
  assign index           = ap_loop_init ? 4'd0 : i;
  assign exit_cond       = ap_start & (index == 4'd8);

  assign ap_done         = exit_cond;
  assign ap_ready        = exit_cond;
  assign ap_idle         = ~ap_start & ~valid1;

  // On the exit cycle index[2:0] is 0, so the discarded read lands at address 0.
  assign temp_V_address0 = index[2:0];
  assign temp_V_ce0      = ap_start;

  always_comb begin
    rom_data = '0;
    case (index[2:0])
      3'd0: rom_data = E_0;
      3'd1: rom_data = E_1;
      3'd2: rom_data = E_2;
      3'd3: rom_data = E_3;
      3'd4: rom_data = E_4;
      3'd5: rom_data = E_5;
      3'd6: rom_data = E_6;
      3'd7: rom_data = E_7;
      default: rom_data = '0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      i         <= '0;
      init_flag <= 1'b1;
      valid1    <= 1'b0;
      idx1      <= '0;
      e_q       <= '0;
    end else begin
      if (temp_V_ce0) e_q <= rom_data;
      valid1 <= ap_start & ~exit_cond;
      if (exit_cond)
        init_flag <= 1'b1;
      else if (ap_start)
        init_flag <= 1'b0;
      if (ap_start && !exit_cond) begin
        idx1 <= index[2:0];
        i    <= index + 4'd1;
      end
    end
  end

  assign ret = {13'b0, e_q} - {temp_V_q0[31], temp_V_q0};

  always_comb begin
    f1_V_d0 = ret[31:0];
    if (ret[32] != ret[31])
      f1_V_d0 = ret[32] ? 32'h80000000 : 32'h7FFFFFFF;
  end

  assign f1_V_address0 = idx1;
  assign f1_V_ce0      = valid1;
  assign f1_V_we0      = valid1;

endmodule

// File: tb/tb_vsub_row_sat_pipeline.sv
// Directed bench for vsub_row_sat_pipeline: expected writes are queued as
// stimulus is issued and popped as the DUT writes f1.
module tb_vsub_row_sat_pipeline;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [2:0]  temp_V_address0;
  logic        temp_V_ce0;
  logic [31:0] temp_V_q0;
  logic [2:0]  f1_V_address0;
  logic        f1_V_ce0;
  logic        f1_V_we0;
  logic [31:0] f1_V_d0;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [2:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  logic [19:0] e_tab [8] = '{20'h00000, 20'h00010, 20'h00100, 20'h01000,
                             20'h10000, 20'h7FFFF, 20'hFFFFF, 20'h00001};
  logic [31:0] temp_mem [8];

  vsub_row_sat_pipeline dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .temp_V_address0(temp_V_address0), .temp_V_ce0(temp_V_ce0), .temp_V_q0(temp_V_q0),
    .f1_V_address0(f1_V_address0), .f1_V_ce0(f1_V_ce0), .f1_V_we0(f1_V_we0),
    .f1_V_d0(f1_V_d0)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) if (temp_V_ce0) temp_V_q0 <= temp_mem[temp_V_address0];

  function automatic logic [31:0] model(int unsigned k, logic [31:0] t);
    longint r;
    r = longint'(e_tab[k]) - longint'($signed(t));
    if (r > 64'sd2147483647) return 32'h7FFFFFFF;
    if (r < -64'sd2147483648) return 32'h80000000;
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned k);
    wr_t w;
    w.addr = k[2:0];
    w.data = model(k, temp_mem[k]);
    sb.push_back(w);
  endtask

  task automatic push_pass();
    for (int unsigned k = 0; k < 8; k++) push(k);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && f1_V_ce0 && f1_V_we0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed addr=%0d data=%h expected no write", f1_V_address0, f1_V_d0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("write_addr", {29'b0, f1_V_address0}, {29'b0, w.addr});
        check("write_data", f1_V_d0, w.data);
      end
    end
  end

  task automatic do_reset();
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    step();
    step();
    ap_rst = 1'b0;
  endtask

  task automatic run_full(input string tag);
    push_pass();
    ap_start = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      #1;
      check({tag, "_done"}, {31'b0, ap_done}, (c == 8) ? 32'd1 : 32'd0);
      check({tag, "_ready"}, {31'b0, ap_ready}, (c == 8) ? 32'd1 : 32'd0);
      check({tag, "_rd_addr"}, {28'b0, temp_V_ce0, temp_V_address0},
            {28'b0, 1'b1, (c == 8) ? 3'd0 : 3'(c)});
      step();
    end
    ap_start = 1'b0;
    #1;
    check({tag, "_idle_after"}, {31'b0, ap_idle}, 32'd1);
    check({tag, "_pending"}, sb.size(), 32'd0);
  endtask

  task automatic clear_temp();
    for (int k = 0; k < 8; k++) temp_mem[k] = 32'h0;
  endtask

  initial begin
    clear_temp();
    ap_start = 1'b0;
    do_reset();
    #1;
    check("rst_idle", {31'b0, ap_idle}, 32'd1);
    check("rst_done", {31'b0, ap_done}, 32'd0);
    check("rst_ready", {31'b0, ap_ready}, 32'd0);
    check("rst_enables", {29'b0, temp_V_ce0, f1_V_ce0, f1_V_we0}, 32'd0);

    run_full("zero");

    temp_mem[1] = 32'h00000020;
    temp_mem[6] = 32'hFFFFFFFF;
    run_full("mixed");
    check("model_f1_1", model(1, 32'h20), 32'hFFFFFFF0);

    clear_temp();
    temp_mem[5] = 32'h80000000;
    temp_mem[0] = 32'h80000000;
    temp_mem[7] = 32'h7FFFFFFF;
    run_full("sat");

    // Continuous start: two full passes plus two elements of a third.
    clear_temp();
    temp_mem[3] = 32'h00000123;
    do_reset();
    push_pass();
    push_pass();
    push(0);
    push(1);
    ap_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("hold_done", {31'b0, ap_done}, (c == 8 || c == 17) ? 32'd1 : 32'd0);
      if (c == 9 || c == 18)
        check("hold_restart_addr", {28'b0, temp_V_ce0, temp_V_address0}, 32'h8);
      step();
    end
    ap_start = 1'b0;
    step();
    step();
    check("hold_pending", sb.size(), 32'd0);

    // Stall for two cycles mid-pass.
    temp_mem[4] = 32'hFFFF0000;
    do_reset();
    push_pass();
    for (int c = 0; c <= 10; c++) begin
      ap_start = !(c == 3 || c == 4);
      #1;
      if (c == 3 || c == 4) begin
        check("stall_rd_ce", {31'b0, temp_V_ce0}, 32'd0);
      end else begin
        check("stall_rd_addr", {28'b0, temp_V_ce0, temp_V_address0},
              {28'b0, 1'b1, (c < 3) ? 3'(c) : (c == 10) ? 3'd0 : 3'(c - 2)});
      end
      if (c == 3) check("stall_drain_we", {28'b0, f1_V_we0, f1_V_address0}, 32'hA);
      if (c == 4) check("stall_idle", {31'b0, ap_idle}, 32'd1);
      check("stall_done", {31'b0, ap_done}, (c == 10) ? 32'd1 : 32'd0);
      step();
    end
    ap_start = 1'b0;
    step();
    check("stall_pending", sb.size(), 32'd0);

    // Reset during cycle 4 of a pass; the in-flight write is ignored.
    do_reset();
    push(0);
    push(1);
    push(2);
    ap_start = 1'b1;
    for (int c = 0; c < 4; c++) step();
    ap_start = 1'b0;
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rst_mid_done", {31'b0, ap_done}, 32'd0);
      check("rst_mid_we", {30'b0, f1_V_we0, f1_V_ce0}, 32'd0);
      check("rst_mid_idle", {31'b0, ap_idle}, 32'd1);
      step();
    end
    check("rst_mid_pending", sb.size(), 32'd0);
    run_full("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vsub_row_sat_pipeline.md
Name: vsub_row_sat_pipeline

Overview:
- Pipelined 8-element vector kernel: f1[i] = sat32(e[i] − temp[i]) for i = 0..7.
- e is a constant 8×20-bit unsigned table held in an internal synchronous ROM.
- temp is read from, and f1 written to, external single-port memories.
- Runs under the standard ap_start/ap_done/ap_ready/ap_idle block handshake, with an internal sequential loop-init flow controller. It is a sub-step of the dense-constraint MPC solver.

Parameters:
- E_0..E_7, defaults 0x00000, 0x00010, 0x00100, 0x01000, 0x10000, 0x7FFFF, 0xFFFFF, 0x00001: ROM contents of e[0..7], 20-bit unsigned.

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  start request
- ap_done  out  1  loop finished
- ap_idle  out  1  no iteration in flight and ap_start low
- ap_ready  out  1  ready for next start, same cycle as ap_done
- temp_V_address0  out  3  temp read address
- temp_V_ce0  out  1  temp read enable
- temp_V_q0  in  32  temp data, signed, valid one cycle after the address
- f1_V_address0  out  3  result write address
- f1_V_ce0  out  1  result enable
- f1_V_we0  out  1  result write enable
- f1_V_d0  out  32  result data, signed

Behaviour:
- Reset state: loop index i = 0; loop-init flag = 1; stage-1 valid = 0; done cache = 0.
- Reset outputs: ap_done = 0, ap_ready = 0, all ce/we = 0. ap_idle = 1 if ap_start = 0.
- Flow controller:
  - ap_start_int = ap_start.
  - ap_loop_init = init_flag & ap_start.
  - init_flag is set at reset and on loop exit, and cleared on any accepted iteration (ap_ready_int).
  - ap_ready = ap_done = exit condition, combinational. The internal continue is tied to 1, so done is never held.
- Stage 0 (active while ap_start = 1):
  - Index used = 0 if ap_loop_init, else the registered i.
  - If index ≠ 8:
    - Drive the ROM and temp_V_address0 with index[2:0] and assert temp_V_ce0.
    - Register the index for stage 1 and set i ← index + 1.
  - If index = 8 (exit cycle):
    - Assert ap_done and ap_ready, and clear stage-1 valid.
    - temp_V_ce0 and the ROM read are still enabled, at address 0. This read is harmless and is discarded.
- Stage 1 (one cycle later, when stage-1 valid):
  - Assert f1_V_ce0 and f1_V_we0, with f1_V_address0 = registered index.
  - ret(33b) = zext(e) − sext(temp_V_q0).
  - If ret[32] ≠ ret[31], output 0x7FFFFFFF when ret[32] = 0, else 0x80000000. Otherwise output ret[31:0].
  - Since e ≥ 0, only positive saturation is reachable.
- Stage-1 valid is loaded with ap_start each cycle, and forced to 0 on the exit cycle.
- ROM: synchronous read, registered when ce is asserted, one-cycle latency. Out-of-range addresses cannot occur with a 3-bit address.
- Timing:
  - Start at cycle 0.
  - Reads for element k in cycle k, write for element k in cycle k+1 (k = 0..7).
  - Exit, with ap_done/ap_ready, in cycle 8; the element-7 write occurs in the same cycle. Total 9 cycles.
- ap_start held high after exit: the loop restarts next cycle at i = 0, with no bubble beyond the exit cycle.
- ap_start dropped mid-loop: stage 0 stalls with i held, and the pending stage-1 write still completes. Resuming continues from i.
- ap_idle = 1 only when ap_start = 0 and stage-1 valid = 0.
- Reset mid-loop: in-flight write abandoned, state returns to reset values next edge.

Test Plan:
- Reset, ap_start = 0 → ap_idle = 1, ap_done = 0, no ce/we asserted.
- temp[i] = 0 for all i, pulse start held 9 cycles → f1[0..7] = E_0..E_7, i.e. 0x0, 0x10, 0x100, 0x1000, 0x10000, 0x7FFFF, 0xFFFFF, 0x1. ap_done/ap_ready high exactly in cycle 8.
- temp[1] = 0x00000020, temp[6] = 0xFFFFFFFF → f1[1] = 0xFFFFFFF0 (−16), f1[6] = 0x00100000.
- temp[5] = 0x80000000 (E_5 = 0x7FFFF) → saturate to f1[5] = 0x7FFFFFFF. Also temp[0] = 0x80000000 → f1[0] = 0x7FFFFFFF, since 0 − (−2^31) overflows.
- ap_start held high for 20 cycles → two complete passes; second pass first read at address 0 in cycle 9, second ap_done in cycle 17.
- Drop ap_start at cycle 3 for 2 cycles → writes 0..2 complete, resume reads at address 3. Also assert ap_rst at cycle 4 of a pass → no further writes, ap_done = 0.
